// File: rtl/os_pkg.sv
// ============================================================================
// Module   : os_pkg
// Brief    : Shared constants and types for the output-stationary datapath.
// Revision : 1.0
// ============================================================================
`default_nettype none

package os_pkg;

    localparam int COL         = 8;
    localparam int PSUM_BW     = 16;
    localparam int OFIFO_DEPTH = 16;

    typedef logic [PSUM_BW-1:0]             psum_t;
    typedef logic [$clog2(OFIFO_DEPTH)-1:0] ofifo_ptr_t;

endpackage

`default_nettype wire

// File: rtl/ofifo_lane.sv
// ============================================================================
// Module   : ofifo_lane
// Brief    : Single-column first-word-fall-through FIFO lane of the OS output bank.
// Revision : 1.0
// ============================================================================
`default_nettype none

module ofifo_lane
    import os_pkg::*;
#(
    parameter int PSUM_BW = os_pkg::PSUM_BW,
    parameter int DEPTH   = OFIFO_DEPTH,
    parameter int PTR_BW  = $clog2(OFIFO_DEPTH)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               wr,
    input  logic               rd,
    input  logic [PSUM_BW-1:0] in,
    output logic [PSUM_BW-1:0] out,
    output logic               empty,
    output logic               full,
    output logic               ovf_pulse
);

    localparam logic [PTR_BW:0] c_depth = (PTR_BW+1)'(DEPTH);

    logic [PSUM_BW-1:0] r_mem [DEPTH];
    logic [PTR_BW-1:0]  r_wptr;
    logic [PTR_BW-1:0]  r_rptr;
    logic [PTR_BW:0]    r_count;
    logic [PTR_BW:0]    w_count_next;
    logic               r_full;
    logic               w_wr_en;

    // rd is the bank-wide qualified pop, so a full lane always has room when it is set
    assign w_wr_en   = wr && (!r_full || rd);
    assign ovf_pulse = wr && r_full && !rd;

    always_comb begin
        w_count_next = r_count;
        if (w_wr_en && !rd)
            w_count_next = r_count + 1'b1;
        else if (!w_wr_en && rd)
            w_count_next = r_count - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (w_wr_en)
            r_mem[r_wptr] <= in;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_full  <= 1'b0;
        end else begin
            if (w_wr_en)
                r_wptr <= r_wptr + 1'b1;
            if (rd)
                r_rptr <= r_rptr + 1'b1;
            r_count <= w_count_next;
            r_full  <= (w_count_next == c_depth);
        end
    end

    assign out   = r_mem[r_rptr];
    assign empty = (r_count == '0);
    assign full  = r_full;

endmodule

`default_nettype wire

// File: rtl/os_ofifo.sv
// ============================================================================
// Module   : os_ofifo
// Brief    : Column-lane output FIFO bank releasing complete aligned rows.
//            Define OFIFO_OVF_CNT_EN to build the saturating dropped-write counter.
// Revision : 1.0
// ============================================================================
`default_nettype none

module os_ofifo
    import os_pkg::*;
#(
    parameter int COL     = os_pkg::COL,
    parameter int PSUM_BW = os_pkg::PSUM_BW,
    parameter int DEPTH   = OFIFO_DEPTH,
    parameter int PTR_BW  = $clog2(OFIFO_DEPTH)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [COL*PSUM_BW-1:0] in,
    input  logic [COL-1:0]         wr,
    input  logic                   rd,
    output logic [COL*PSUM_BW-1:0] out,
    output logic                   o_valid,
    output logic                   o_full,
    output logic                   o_ovf,
    output logic [7:0]             ovf_cnt
);

    logic [COL*PSUM_BW-1:0] w_row;
    logic [COL-1:0]         w_empty;
    logic [COL-1:0]         w_full;
    logic [COL-1:0]         w_ovf;
    logic                   w_pop;
    logic                   r_ovf;

    assign w_pop = rd && o_valid;

    generate
        for (genvar c = 0; c < COL; c++) begin : g_lane
            ofifo_lane #(
                .PSUM_BW (PSUM_BW),
                .DEPTH   (DEPTH),
                .PTR_BW  (PTR_BW)
            ) u_lane (
                .clk       (clk),
                .reset     (reset),
                .wr        (wr[c]),
                .rd        (w_pop),
                .in        (in[c*PSUM_BW +: PSUM_BW]),
                .out       (w_row[c*PSUM_BW +: PSUM_BW]),
                .empty     (w_empty[c]),
                .full      (w_full[c]),
                .ovf_pulse (w_ovf[c])
            );
        end
    endgenerate

    assign o_valid = ~|w_empty;
    assign o_full  = |w_full;
    assign out     = o_valid ? w_row : '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_ovf <= 1'b0;
        else if (|w_ovf)
            r_ovf <= 1'b1;
    end

    assign o_ovf = r_ovf;

`ifdef OFIFO_OVF_CNT_EN
    logic [7:0] r_ovf_cnt;
    logic [8:0] w_drop_sum;

    // several lanes may drop in one cycle; add them all before saturating
    always_comb begin
        w_drop_sum = {1'b0, r_ovf_cnt};
        for (int c = 0; c < COL; c++)
            w_drop_sum = w_drop_sum + 9'(w_ovf[c]);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_ovf_cnt <= '0;
        else
            r_ovf_cnt <= w_drop_sum[8] ? 8'hFF : w_drop_sum[7:0];
    end

    assign ovf_cnt = r_ovf_cnt;
`else
    assign ovf_cnt = '0;
`endif

endmodule

`default_nettype wire
